pipe_field: RTL and testbench
=============================

PIPE_FIELD -- requirements
Module: pipe_field

Interface
REQ-001 SHALL have parameter N_PIPES, default 4: number of obstacle slots.
REQ-002 SHALL have parameter WIDTH, default 32: obstacle width, pixels.
REQ-003 SHALL have parameter GAP_HEIGHT, default 50: vertical opening, pixels.
REQ-004 SHALL have parameter Y_TOP, default 208: top row of the playfield.
REQ-005 SHALL have parameter FIELD_HEIGHT, default 512: playfield height, pixels.
REQ-006 SHALL have parameter SCREEN_W, default 1280: spawn x coordinate.
REQ-007 SHALL have parameter SPEED, default 2: pixels moved per frame.
REQ-008 SHALL have parameter SPAWN_FRAMES, default 160: frames between spawn attempts.
REQ-009 SHALL have parameter COLOR, default 24'h00_C0_00: obstacle RGB.
REQ-010 SHALL have port clk, input, 1: the only clock.
REQ-011 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-012 SHALL have port new_frame, input, 1: one-cycle pulse per frame, issued during blanking.
REQ-013 SHALL have port enable, input, 1: when low, frame updates freeze and obstacles stay drawn.
REQ-014 SHALL have ports hcount_in, input, 11, and vcount_in, input, 10: pixel coordinates.
REQ-015 SHALL have ports freq_in, input, 16, and freq_valid, input, 1: pitch sample and its qualifier.
REQ-016 SHALL have ports bird_x, input, 11, and bird_y, input, 10: player position.
REQ-017 SHALL have port clear_collision, input, 1: clears the collision flag.
REQ-018 SHALL have ports red_out, green_out and blue_out, output, 8 each: pixel colour.
REQ-019 SHALL have port collision, output, 1: sticky hit flag.
REQ-020 SHALL have port pass_count, output, 8: count of obstacles passed.
REQ-021 SHALL have port gap_height, output, 9: Y_TOP plus the gap top of the newest spawn.

Function
REQ-022 SHALL hold, per slot, an active bit, a signed 13-bit x and a 9-bit gap_pos.
REQ-023 SHALL capture freq_in into freq_lat on every cycle that freq_valid is high.
REQ-024 SHALL, on new_frame with enable high, reduce every active x by SPEED.
REQ-025 SHALL, on that same update, deactivate a slot whose new x is <= -WIDTH.
REQ-026 SHALL decrement a frame counter on each enabled new_frame; at zero it attempts a spawn and reloads to SPAWN_FRAMES-1.
REQ-027 SHALL, on a spawn, fill the lowest-index inactive slot: x=SCREEN_W, gap_pos=min(freq_lat>>2, FIELD_HEIGHT-GAP_HEIGHT).
REQ-028 SHALL drop a spawn silently when all slots are active; the counter still reloads.
REQ-029 SHALL let a slot freed and a spawn in the same update reuse that slot.
REQ-030 SHALL count a pass when a slot's x+WIDTH goes from > bird_x to <= bird_x within one update; pass_count adds the number of slots that passed, saturating at 255.
REQ-031 SHALL treat a pixel as inside a slot when the slot is active, x <= hcount_in < x+WIDTH and Y_TOP <= vcount_in < Y_TOP+FIELD_HEIGHT, excluding the gap rows Y_TOP+gap_pos to Y_TOP+gap_pos+GAP_HEIGHT-1.
REQ-032 SHALL register the pixel output with exactly 2 cycles of latency (per-slot hit compare, then OR and colour); the output is COLOR on a hit and 0 otherwise.
REQ-033 SHALL set collision when the stage-2 hit is high and the delayed coordinates equal (bird_x, bird_y).
REQ-034 SHALL give set priority over clear_collision when both occur in the same cycle.
REQ-035 SHALL apply frame updates only on new_frame, so geometry is stable while a frame is drawn.

Reset
REQ-036 SHALL, while rst is low, clear all slots inactive, x to 0 and gap_pos to 0.
REQ-037 SHALL, while rst is low, load the frame counter with SPAWN_FRAMES-1 and clear freq_lat, pass_count, collision, the pipeline registers and the RGB outputs to 0.
REQ-038 SHALL, while rst is low, hold gap_height at Y_TOP.
REQ-039 SHALL apply reset asynchronously at any time, including mid-frame, and SHALL release it synchronously to clk.

Structure
REQ-040 SHALL place the coordinate typedefs, the slot record type and the default constants in the shared package pipe_field_pkg.
REQ-041 SHALL place per-slot move, spawn, expire and pass logic in the sub-module pipe_slot, instantiated N_PIPES times.

Verification
REQ-042 SHALL cover spawn: freq_valid with freq_in=400, then SPAWN_FRAMES frames -> slot0 active at x=1280, gap_pos=100, gap_height=308.
REQ-043 SHALL cover the gap clamp: freq_in=4000 -> gap_pos=462.
REQ-044 SHALL cover scroll and expiry: slot at x=-30 after one frame -> x=-32, slot inactive.
REQ-045 SHALL cover overflow: N_PIPES=2, three spawns with no expiry -> third spawn dropped, pass_count unchanged.
REQ-046 SHALL cover pixel and collision: hcount=x+5, vcount=Y_TOP+gap_pos-1 -> COLOR two cycles later, and collision set when bird is at that point.
REQ-047 SHALL cover reset mid-frame: rst low during an active line -> RGB 0, collision 0, pass_count 0 immediately.

Source files
------------

// File: rtl/pipe_field_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_field_pkg
// Description : Shared types and default constants for the scrolling
//               obstacle field: screen coordinate types, the per-slot
//               record and the default geometry/timing values.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_field_pkg;

    typedef logic [10:0]        hcoord_t;   // horizontal pixel coordinate
    typedef logic [9:0]         vcoord_t;   // vertical pixel coordinate
    typedef logic signed [12:0] xpos_t;     // obstacle x, may go off-screen left
    typedef logic [8:0]         gap_t;      // gap top, relative to Y_TOP

    typedef struct packed {
        logic  active;
        xpos_t x;
        gap_t  gap_pos;
    } slot_t;

    localparam int          DEF_N_PIPES      = 4;
    localparam int          DEF_WIDTH        = 32;
    localparam int          DEF_GAP_HEIGHT   = 50;
    localparam int          DEF_Y_TOP        = 208;
    localparam int          DEF_FIELD_HEIGHT = 512;
    localparam int          DEF_SCREEN_W     = 1280;
    localparam int          DEF_SPEED        = 2;
    localparam int          DEF_SPAWN_FRAMES = 160;
    localparam logic [23:0] DEF_COLOR        = 24'h00_C0_00;

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One obstacle slot. Scrolls left on each frame update,
//               expires once fully off the left edge, loads a fresh
//               obstacle when selected for a spawn and flags a pass when
//               its right edge crosses the player column.
// Ports       : clk, rst (async, active-low)
//               update    - enabled frame update strobe
//               spawn     - this slot receives the spawn in this update
//               spawn_gap - gap top for the spawned obstacle
//               bird_x    - player column
//               slot      - current slot record
//               free_next - slot is empty after this update's move/expire
//               passed    - right edge crossed bird_x in this update
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
    import pipe_field_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SPEED    = DEF_SPEED
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    update,
    input  logic    spawn,
    input  gap_t    spawn_gap,
    input  hcoord_t bird_x,
    output slot_t   slot,
    output logic    free_next,
    output logic    passed
);

    localparam logic signed [13:0] W_S   = 14'(WIDTH);
    localparam logic signed [13:0] SPD_S = 14'(SPEED);

    slot_t                r_slot;
    logic signed [13:0]   w_x_old;
    logic signed [13:0]   w_x_moved;
    logic signed [13:0]   w_bird;
    logic                 w_expire;

    assign w_x_old   = {r_slot.x[12], r_slot.x};
    assign w_x_moved = w_x_old - SPD_S;
    assign w_bird    = {3'b000, bird_x};

    assign w_expire  = r_slot.active && (w_x_moved <= -W_S);
    // An expiring slot counts as free so a spawn in the same update reuses it.
    assign free_next = !r_slot.active || w_expire;
    assign passed    = update && r_slot.active
                       && ((w_x_old + W_S) > w_bird)
                       && ((w_x_moved + W_S) <= w_bird);
    assign slot      = r_slot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot <= '0;
        end else if (update) begin
            if (spawn) begin
                r_slot.active  <= 1'b1;
                r_slot.x       <= 13'(SCREEN_W);
                r_slot.gap_pos <= spawn_gap;
            end else if (r_slot.active) begin
                r_slot.x      <= w_x_moved[12:0];
                r_slot.active <= !w_expire;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_field.sv
`default_nettype none
// ============================================================================
// Module      : pipe_field
// Description : Scrolling obstacle field. Spawns obstacles whose gap height
//               follows a latched pitch sample, scrolls them once per frame,
//               counts obstacles passed, renders them with a two-stage pixel
//               pipeline and raises a sticky collision flag.
// Ports       : clk, rst (async, active-low), new_frame, enable
//               hcount_in/vcount_in   - pixel being drawn
//               freq_in/freq_valid    - pitch sample and qualifier
//               bird_x/bird_y         - player position
//               clear_collision       - clears the collision flag
//               red_out/green_out/blue_out - pixel colour (2-cycle latency)
//               collision, pass_count, gap_height - game status
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_field
    import pipe_field_pkg::*;
#(
    parameter int          N_PIPES      = DEF_N_PIPES,
    parameter int          WIDTH        = DEF_WIDTH,
    parameter int          GAP_HEIGHT   = DEF_GAP_HEIGHT,
    parameter int          Y_TOP        = DEF_Y_TOP,
    parameter int          FIELD_HEIGHT = DEF_FIELD_HEIGHT,
    parameter int          SCREEN_W     = DEF_SCREEN_W,
    parameter int          SPEED        = DEF_SPEED,
    parameter int          SPAWN_FRAMES = DEF_SPAWN_FRAMES,
    parameter logic [23:0] COLOR        = DEF_COLOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_frame,
    input  logic        enable,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [15:0] freq_in,
    input  logic        freq_valid,
    input  logic [10:0] bird_x,
    input  logic [9:0]  bird_y,
    input  logic        clear_collision,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        collision,
    output logic [7:0]  pass_count,
    output logic [8:0]  gap_height
);

    localparam logic [15:0]        GAP_MAX  = 16'(FIELD_HEIGHT - GAP_HEIGHT);
    localparam logic [15:0]        CNT_LOAD = 16'(SPAWN_FRAMES - 1);
    localparam logic [11:0]        V_LO     = 12'(Y_TOP);
    localparam logic [11:0]        V_HI     = 12'(Y_TOP + FIELD_HEIGHT);
    localparam logic [11:0]        GAP_H    = 12'(GAP_HEIGHT);
    localparam logic signed [13:0] W_S      = 14'(WIDTH);

    logic [15:0]         r_freq_lat;
    logic [15:0]         r_frame_cnt;
    logic [15:0]         w_gap_raw;
    gap_t                w_gap;
    logic                w_update;
    logic                w_spawn_try;
    logic                w_spawn_ok;
    logic [N_PIPES-1:0]  w_free_next;
    logic [N_PIPES-1:0]  w_spawn_sel;
    logic [N_PIPES-1:0]  w_passed;
    logic [N_PIPES-1:0]  w_hit;
    logic [N_PIPES-1:0]  r_hit_vec;
    slot_t               w_slots [N_PIPES];
    logic [15:0]         w_pass_num;
    logic [15:0]         w_pass_sum;
    logic signed [13:0]  w_h;
    logic [11:0]         w_v;
    hcoord_t             r_h1;
    vcoord_t             r_v1;
    logic                w_hit2;

    assign w_update    = new_frame && enable;
    assign w_spawn_try = w_update && (r_frame_cnt == 16'd0);
    assign w_gap_raw   = r_freq_lat >> 2;
    assign w_gap       = (w_gap_raw > GAP_MAX) ? GAP_MAX[8:0] : w_gap_raw[8:0];
    assign w_h         = {3'b000, hcount_in};
    assign w_v         = {2'b00, vcount_in};

    // Lowest-index slot that is free after this update's move/expire.
    always_comb begin
        w_spawn_sel = '0;
        w_spawn_ok  = 1'b0;
        if (w_spawn_try) begin
            for (int i = 0; i < N_PIPES; i++) begin
                if (!w_spawn_ok && w_free_next[i]) begin
                    w_spawn_sel[i] = 1'b1;
                    w_spawn_ok     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_pass_num = '0;
        for (int i = 0; i < N_PIPES; i++) begin
            w_pass_num = w_pass_num + 16'(w_passed[i]);
        end
    end
    assign w_pass_sum = 16'(pass_count) + w_pass_num;

    for (genvar gi = 0; gi < N_PIPES; gi++) begin : g_slot
        logic signed [13:0] w_xl;
        logic [11:0]        w_gap_lo;
        logic               w_in_x;
        logic               w_in_y;
        logic               w_in_gap;

        pipe_slot #(
            .WIDTH    (WIDTH),
            .SCREEN_W (SCREEN_W),
            .SPEED    (SPEED)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .update    (w_update),
            .spawn     (w_spawn_sel[gi]),
            .spawn_gap (w_gap),
            .bird_x    (bird_x),
            .slot      (w_slots[gi]),
            .free_next (w_free_next[gi]),
            .passed    (w_passed[gi])
        );

        assign w_xl     = {w_slots[gi].x[12], w_slots[gi].x};
        assign w_gap_lo = V_LO + {3'b000, w_slots[gi].gap_pos};
        assign w_in_x   = (w_h >= w_xl) && (w_h < (w_xl + W_S));
        assign w_in_y   = (w_v >= V_LO) && (w_v < V_HI);
        assign w_in_gap = (w_v >= w_gap_lo) && (w_v < (w_gap_lo + GAP_H));
        assign w_hit[gi] = w_slots[gi].active && w_in_x && w_in_y && !w_in_gap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_freq_lat <= '0;
        end else if (freq_valid) begin
            r_freq_lat <= freq_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= CNT_LOAD;
            pass_count  <= '0;
            gap_height  <= 9'(Y_TOP);
        end else if (w_update) begin
            // Counter reloads on every attempt, including dropped spawns.
            r_frame_cnt <= (r_frame_cnt == 16'd0) ? CNT_LOAD : r_frame_cnt - 16'd1;
            if (w_spawn_ok) begin
                gap_height <= 9'(Y_TOP) + w_gap;
            end
            pass_count <= (w_pass_sum > 16'd255) ? 8'd255 : w_pass_sum[7:0];
        end
    end

    // Stage 1 registers per-slot hits; stage 2 merges them into colour and
    // the collision flag, using coordinates delayed to match.
    assign w_hit2 = |r_hit_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_vec <= '0;
            r_h1      <= '0;
            r_v1      <= '0;
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
            collision <= 1'b0;
        end else begin
            r_hit_vec <= w_hit;
            r_h1      <= hcount_in;
            r_v1      <= vcount_in;
            {red_out, green_out, blue_out} <= w_hit2 ? COLOR : 24'h00_00_00;
            if (w_hit2 && (r_h1 == bird_x) && (r_v1 == bird_y)) begin
                collision <= 1'b1;
            end else if (clear_collision) begin
                collision <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_field.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_field
// Description : Self-checking bench for pipe_field (N_PIPES=2, other
//               parameters at default). Pixel probes push an expected record
//               into a scoreboard; a monitor pops and compares colour and
//               status when the probe emerges from the 2-cycle pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_field;

    localparam logic [23:0] COL = 24'h00_C0_00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        new_frame = 1'b0;
    logic        enable = 1'b1;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic [15:0] freq_in = '0;
    logic        freq_valid = 1'b0;
    logic [10:0] bird_x = 11'd100;
    logic [9:0]  bird_y = 10'd300;
    logic        clear_collision = 1'b0;
    logic [7:0]  red_out, green_out, blue_out, pass_count;
    logic        collision;
    logic [8:0]  gap_height;

    always #5 clk = ~clk;

    pipe_field #(.N_PIPES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .new_frame       (new_frame),
        .enable          (enable),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .freq_in         (freq_in),
        .freq_valid      (freq_valid),
        .bird_x          (bird_x),
        .bird_y          (bird_y),
        .clear_collision (clear_collision),
        .red_out         (red_out),
        .green_out       (green_out),
        .blue_out        (blue_out),
        .collision       (collision),
        .pass_count      (pass_count),
        .gap_height      (gap_height)
    );

    typedef struct {
        string      name;
        logic [23:0] rgb;
        logic       col;
        logic [7:0] pc;
        logic [8:0] gh;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    logic probe = 1'b0;
    logic pv1, pv2;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Probe marker travels alongside the DUT pixel pipeline.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv1 <= 1'b0;
            pv2 <= 1'b0;
        end else begin
            pv1 <= probe;
            pv2 <= pv1;
        end
    end

    always @(negedge clk) begin
        if (rst && pv2) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: scoreboard empty");
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, ".rgb"}, 32'({red_out, green_out, blue_out}), 32'(mon_e.rgb));
                chk({mon_e.name, ".collision"}, 32'(collision), 32'(mon_e.col));
                chk({mon_e.name, ".pass_count"}, 32'(pass_count), 32'(mon_e.pc));
                chk({mon_e.name, ".gap_height"}, 32'(gap_height), 32'(mon_e.gh));
            end
        end
    end

    // Called at #1 after a rising edge; returns at #1 after a rising edge.
    task automatic probe_px(input string nm, input int h, input int v, input logic hit,
                            input logic col, input int pc, input int gh, input logic clr);
        exp_t e;
        e.name = nm;
        e.rgb  = hit ? COL : 24'h0;
        e.col  = col;
        e.pc   = 8'(pc);
        e.gh   = 9'(gh);
        sb.push_back(e);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        probe     = 1'b1;
        @(posedge clk); #1;
        probe           = 1'b0;
        hcount_in       = '0;
        vcount_in       = '0;
        clear_collision = clr;
        @(posedge clk); #1;
        clear_collision = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            new_frame = 1'b1;
            @(posedge clk); #1;
            new_frame = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic latch_freq(input logic [15:0] f);
        freq_in    = f;
        freq_valid = 1'b1;
        @(posedge clk); #1;
        freq_valid = 1'b0;
        freq_in    = 16'd9999;   // must be ignored while freq_valid is low
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset.rgb", 32'({red_out, green_out, blue_out}), 32'h0);
        chk("reset.collision", 32'(collision), 32'h0);
        chk("reset.pass_count", 32'(pass_count), 32'h0);
        chk("reset.gap_height", 32'(gap_height), 32'd208);
        rst = 1'b1;
        @(posedge clk); #1;

        // Spawn: 400>>2 = 100, gap rows 308..357, gap_height 308
        latch_freq(16'd400);
        frames(159);
        probe_px("pre_spawn", 1285, 307, 1'b0, 1'b0, 0, 208, 1'b0);
        frames(1);
        probe_px("gap_above",      1285, 307, 1'b1, 1'b0, 0, 308, 1'b0);
        probe_px("gap_first",      1285, 308, 1'b0, 1'b0, 0, 308, 1'b0);
        probe_px("gap_last",       1285, 357, 1'b0, 1'b0, 0, 308, 1'b0);
        probe_px("gap_below",      1285, 358, 1'b1, 1'b0, 0, 308, 1'b0);
        probe_px("above_field",    1285, 207, 1'b0, 1'b0, 0, 308, 1'b0);
        probe_px("field_last",     1285, 719, 1'b1, 1'b0, 0, 308, 1'b0);
        probe_px("below_field",    1285, 720, 1'b0, 1'b0, 0, 308, 1'b0);
        probe_px("left_edge_out",  1279, 250, 1'b0, 1'b0, 0, 308, 1'b0);
        probe_px("left_edge_in",   1280, 250, 1'b1, 1'b0, 0, 308, 1'b0);
        probe_px("right_edge_in",  1311, 250, 1'b1, 1'b0, 0, 308, 1'b0);
        probe_px("right_edge_out", 1312, 250, 1'b0, 1'b0, 0, 308, 1'b0);

        // Clamp: 4000>>2 = 1000 -> 462; gap rows 670..719.
        // gap_height = (208+462) mod 512 = 158 in the 9-bit port.
        latch_freq(16'd4000);
        frames(160);   // frame 320: slot0 x=960, slot1 spawned
        probe_px("clamp_above",   1285, 669, 1'b1, 1'b0, 0, 158, 1'b0);
        probe_px("clamp_gap",     1285, 670, 1'b0, 1'b0, 0, 158, 1'b0);
        probe_px("clamp_bottom",  1285, 719, 1'b0, 1'b0, 0, 158, 1'b0);
        probe_px("slot0_x960_in", 960,  250, 1'b1, 1'b0, 0, 158, 1'b0);
        probe_px("slot0_x960_out", 959, 250, 1'b0, 1'b0, 0, 158, 1'b0);

        // Overflow: frame 480 spawn dropped, both slots untouched
        frames(160);
        probe_px("drop_no_new",     1285, 250, 1'b0, 1'b0, 0, 158, 1'b0);
        probe_px("drop_slot0_kept", 640,  250, 1'b1, 1'b0, 0, 158, 1'b0);
        probe_px("drop_slot1_kept", 960,  250, 1'b1, 1'b0, 0, 158, 1'b0);

        // Frame 815: slot0 x=-30 (passed bird at frame 766), slot1 x=290
        frames(335);
        probe_px("near_expiry_in",  1, 250, 1'b1, 1'b0, 1, 158, 1'b0);
        probe_px("near_expiry_out", 2, 250, 1'b0, 1'b0, 1, 158, 1'b0);

        // Frame 816 slot0 expires at x=-32; frame 960 respawns into slot0.
        // slot1 passed at frame 926 and sits at x=0.
        frames(145);
        probe_px("respawn_slot0",  1285, 250, 1'b1, 1'b0, 2, 158, 1'b0);
        probe_px("slot1_x0_in",    31,   250, 1'b1, 1'b0, 2, 158, 1'b0);
        probe_px("slot1_x0_out",   32,   250, 1'b0, 1'b0, 2, 158, 1'b0);

        // Freeze with enable low
        enable = 1'b0;
        frames(10);
        probe_px("frozen_in",  1280, 250, 1'b1, 1'b0, 2, 158, 1'b0);
        probe_px("frozen_out", 1279, 250, 1'b0, 1'b0, 2, 158, 1'b0);
        enable = 1'b1;

        // Collision
        bird_x = 11'd1285;
        bird_y = 10'd250;
        probe_px("hit_bird", 1285, 250, 1'b1, 1'b1, 2, 158, 1'b0);
        probe_px("sticky",   0,    0,   1'b0, 1'b1, 2, 158, 1'b0);
        clear_collision = 1'b1;
        @(posedge clk); #1;
        clear_collision = 1'b0;
        probe_px("cleared",         0,    0,   1'b0, 1'b0, 2, 158, 1'b0);
        probe_px("set_beats_clear", 1285, 250, 1'b1, 1'b1, 2, 158, 1'b1);

        // Reset mid-line while drawing an obstacle pixel
        hcount_in = 11'd1285;
        vcount_in = 10'd250;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset.rgb", 32'({red_out, green_out, blue_out}), 32'(COL));
        rst = 1'b0;
        #1;
        chk("mid_reset.rgb", 32'({red_out, green_out, blue_out}), 32'h0);
        chk("mid_reset.collision", 32'(collision), 32'h0);
        chk("mid_reset.pass_count", 32'(pass_count), 32'h0);
        chk("mid_reset.gap_height", 32'(gap_height), 32'd208);
        hcount_in = '0;
        vcount_in = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        probe_px("post_reset_empty", 1285, 250, 1'b0, 1'b0, 0, 208, 1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d probes never emerged", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
